core_dmem_ram: RTL
==================

# core_dmem_ram

Single-port data-memory responder that terminates the core's `dmem_*` request/grant interface. It answers load/store requests issued by the execute stage and consumed by writeback. Read data is always returned as a full aligned doubleword; writeback performs byte/half/word extraction and sign extension. A programmable wait-state counter lets benches and SoC tops model slow memories, and an address-range check raises `dmem_err`.

## Interface
- `BASE` — default 64'h0000_0000_0001_0000 — byte address of word 0; must be 8-byte aligned.
- `DEPTH_W` — default 12 — log2 of doubleword count (default 4096 x 64 bits = 32 KiB).
- `WAIT` — default 0 — wait cycles before grant, range 0..15.

Ports:
- `g_clk` — in — 1 — clock; all state updates on the rising edge.
- `g_resetn` — in — 1 — reset; synchronous, active-low.
- `dmem_req` — in — 1 — request valid; held until granted.
- `dmem_addr` — in — MEM_ADDR_R+1 — byte address.
- `dmem_wen` — in — 1 — 1 = store, 0 = load.
- `dmem_strb` — in — 8 — byte-lane write strobes; lane i = bits [8i+7:8i].
- `dmem_wdata` — in — 64 — store data, lane-aligned.
- `dmem_gnt` — out — 1 — request accepted this cycle.
- `dmem_err` — out — 1 — response error for last granted request.
- `dmem_rdata` — out — 64 — response read data for last granted load.

## Operation
- Transaction accepted when `dmem_req && dmem_gnt` is high at a clock edge ("grant edge").
- Wait counter `wcnt`, 4 bits:
  - Reset value 0.
  - `dmem_gnt = dmem_req && (wcnt == WAIT)`, combinational; with WAIT=0, gnt follows req in the same cycle.
  - If `dmem_req && !dmem_gnt`: `wcnt <= wcnt + 1`.
  - On a grant edge, or when `dmem_req` is low: `wcnt <= 0`.
  - A request dropped mid-wait restarts the count from 0 when it is reasserted.
- Range check:
  - `offs = dmem_addr - BASE`.
  - `in_range = dmem_addr >= BASE && offs < (8 << DEPTH_W)`.
  - `idx = offs[DEPTH_W+2:3]`; `addr[2:0]` is ignored by the array.
- Store grant, in range: each lane with its strobe set takes `dmem_wdata`; other lanes are unchanged. `dmem_rdata` is unchanged. `dmem_err <= 0`.
- Store grant, out of range: the array is not modified. `dmem_err <= 1`. `dmem_rdata` is unchanged.
- Load grant, in range: `dmem_rdata <= mem[idx]`, the full doubleword regardless of strobes. `dmem_err <= 0`.
- Load grant, out of range: `dmem_rdata <= 0`. `dmem_err <= 1`.
- `dmem_rdata` and `dmem_err` hold their values until the next grant edge (sticky response).
- Array contents are not reset. Simulation starts from X unless a bench preloads the array hierarchically.

## Timing
- Reset values: `dmem_gnt=0` (because `wcnt=0` and the requester must drop req during reset), `dmem_err=0`, `dmem_rdata=0`, `wcnt=0`.
- Load latency: data is valid on `dmem_rdata` in the cycle after the grant edge. Total request-to-data time is WAIT+1 cycles.
- Store latency: the array is updated at the grant edge. A load granted on the following cycle returns the new data (read-after-write, no hazard).
- Back-to-back requests: with WAIT=0, one transaction is granted per cycle. With WAIT=N, there is at most one grant every N+1 cycles of continuous req.
- Reset mid-wait: `wcnt` clears and no grant occurs that cycle. A pending store is not performed.
- Reset in the cycle after a grant: the response registers clear to 0 on that edge. A store already committed at the earlier grant edge stays in the array.
- Address arithmetic is performed at full MEM_ADDR_R+1 width, so addresses below BASE wrap to a large `offs` and are flagged out of range.

## Test plan
- WAIT=0: store `64'h1122334455667788` strb=8'hFF to BASE+8, then load BASE+8 the next cycle.
  - Required: gnt in both request cycles; `dmem_rdata=64'h1122334455667788` and `err=0` one cycle after the load grant.
- Partial store: store `wdata=64'hAAAA_AAAA_AAAA_AAAA` strb=8'h0C to BASE+8, then load BASE+8.
  - Required: `rdata=64'h11223344AAAA7788`.
- WAIT=3: hold a load req continuously.
  - Required: gnt is low for 3 cycles and high on the 4th; data appears on the 5th cycle; `wcnt` returns to 0.
- Out of range: load BASE-8, then store to BASE+(8<<DEPTH_W).
  - Required: `err=1` and `rdata=0` after each grant; a load of the last valid word, BASE+(8<<DEPTH_W)-8, still returns its prior contents with `err=0`.
- Dropped request with WAIT=3: assert req for 2 cycles, drop it for 1, reassert.
  - Required: gnt arrives 3 wait cycles after reassertion, not earlier.
- Reset: assert g_resetn=0 for one cycle with req held mid-wait.
  - Required: next cycle `gnt=0`, `err=0`, `rdata=0`, and the array is unmodified.

Source files
------------

// File: rtl/core_dmem_ram.sv
// core_dmem_ram
//
// Single-port data memory that terminates the core's dmem request/grant
// interface. Loads return the full aligned doubleword; byte/half/word
// extraction and sign extension happen in writeback. A programmable
// wait-state counter delays each grant by WAIT cycles, and requests
// outside [BASE, BASE + 8*2^DEPTH_W) complete with dmem_err set.
//
// Parameters:
//   MEM_ADDR_R  msb index of the byte address (address is MEM_ADDR_R+1 bits)
//   BASE        byte address of doubleword 0 (8-byte aligned)
//   DEPTH_W     log2 of the doubleword count
//   WAIT        wait cycles before grant, 0..15
//
// Ports:
//   g_clk       clock, rising edge
//   g_resetn    synchronous active-low reset
//   dmem_req    request valid, held by the requester until granted
//   dmem_addr   byte address
//   dmem_wen    1 = store, 0 = load
//   dmem_strb   byte-lane write strobes, lane i = bits [8i+7:8i]
//   dmem_wdata  lane-aligned store data
//   dmem_gnt    request accepted this cycle (combinational)
//   dmem_err    error flag of the last granted request (sticky)
//   dmem_rdata  read data of the last granted load (sticky)

module core_dmem_ram #(
  parameter int unsigned MEM_ADDR_R = 63,
  parameter logic [63:0] BASE       = 64'h0000_0000_0001_0000,
  parameter int unsigned DEPTH_W    = 12,
  parameter int unsigned WAIT       = 0
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  dmem_req,
  input  logic [MEM_ADDR_R:0]   dmem_addr,
  input  logic                  dmem_wen,
  input  logic [7:0]            dmem_strb,
  input  logic [63:0]           dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [63:0]           dmem_rdata
);

  localparam int unsigned AW     = MEM_ADDR_R + 1;
  localparam logic [AW-1:0] BASE_A = BASE[AW-1:0];
  // Size of the window in bytes, computed at the full address width so the
  // comparison against offs has no truncation.
  localparam logic [AW-1:0] SPAN   = AW'(64'd8 << DEPTH_W);
  localparam logic [3:0]    WAIT_C = 4'(WAIT);

  logic [3:0]         wcnt_q, wcnt_d;
  logic               err_q, err_d;
  logic [63:0]        rdata_q, rdata_d;

  logic [AW-1:0]      offs;
  logic               in_range;
  logic [DEPTH_W-1:0] idx;
  logic               mem_we;

  logic [63:0]        mem [2**DEPTH_W];

  // Address decode. Addresses below BASE wrap to a huge offs, so the
  // lower-bound test is only a belt-and-braces guard on the subtraction.
  always_comb begin
    offs     = dmem_addr - BASE_A;
    in_range = (dmem_addr >= BASE_A) && (offs < SPAN);
    idx      = offs[DEPTH_W+2:3];
  end

  // Grant is suppressed while in reset so that a request held across reset
  // can never commit a store on the reset edge.
  assign dmem_gnt = g_resetn && dmem_req && (wcnt_q == WAIT_C);
  assign mem_we   = dmem_gnt && dmem_wen && in_range;

  // NOTE: every variable is given its hold value first so no path through
  // this block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    if (!dmem_req || dmem_gnt) begin
      wcnt_d = '0;
    end else begin
      wcnt_d = wcnt_q + 4'd1;
    end

    if (dmem_gnt) begin
      err_d = !in_range;
      if (!dmem_wen) begin
        rdata_d = in_range ? mem[idx] : 64'd0;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM macros; its contents
  // survive g_resetn and start undefined after power-up.
  always_ff @(posedge g_clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (dmem_strb[i]) begin
          mem[idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign dmem_err   = err_q;
  assign dmem_rdata = rdata_q;

endmodule
